// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial WIDTH-bit subtractor (diff = a - b - bin).
// One full-subtractor cell is reused over WIDTH cycles, LSB first, and the
// borrow is chained through a register. Handshake: start / busy / done.
// Optional flags (zero, neg, ovf) are built when SERIAL_SUB_FLAGS_EN is defined.
module serial_sub_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_FLAGS_EN
  output logic             zero,
  output logic             neg,
  output logic             ovf,
`endif
  output logic             bout
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   res_sr_q, res_sr_d;
  logic               brw_q, brw_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               d_bit;
  logic               brw_nxt;
  logic [WIDTH-1:0]   res_nxt;

`ifdef SERIAL_SUB_FLAGS_EN
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic               zero_q, zero_d;
  logic               neg_q, neg_d;
  logic               ovf_q, ovf_d;
`endif

  // Next-state, datapath step and registered-output computation
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    brw_d    = brw_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
`ifdef SERIAL_SUB_FLAGS_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
`endif

    // Single full-subtractor cell on the current LSBs
    d_bit   = a_sr_q[0] ^ b_sr_q[0] ^ brw_q;
    brw_nxt = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & brw_q);
    res_nxt = {d_bit, res_sr_q[WIDTH-1:1]};

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_sr_d   = a;
          b_sr_d   = b;
          brw_d    = bin;
          res_sr_d = '0;
          cnt_d    = '0;
`ifdef SERIAL_SUB_FLAGS_EN
          a_msb_d  = a[WIDTH-1];
          b_msb_d  = b[WIDTH-1];
`endif
          state_d  = S_RUN;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        res_sr_d = res_nxt;
        brw_d    = brw_nxt;
        if (cnt_q == CNT_LAST) begin
          diff_d  = res_nxt;
          bout_d  = brw_nxt;
`ifdef SERIAL_SUB_FLAGS_EN
          zero_d  = (res_nxt == '0);
          neg_d   = d_bit;
          ovf_d   = (a_msb_q ^ b_msb_q) & (a_msb_q ^ d_bit);
`endif
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      brw_q    <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      brw_q    <= brw_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

`ifdef SERIAL_SUB_FLAGS_EN
  // Status flag registers, updated alongside diff
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
    end
  end

  assign zero = zero_q;
  assign neg  = neg_q;
  assign ovf  = ovf_q;
`endif

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed self-checking bench for serial_sub_ctrl (WIDTH=8).
// Flag checks are included when SERIAL_SUB_FLAGS_EN is defined.
module tb_serial_sub_ctrl;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_FLAGS_EN
  logic         zero;
  logic         neg;
  logic         ovf;
`endif

  int n_tests;
  int n_fail;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
`ifdef SERIAL_SUB_FLAGS_EN
    .zero  (zero),
    .neg   (neg),
    .ovf   (ovf),
`endif
    .bout  (bout)
  );

  // 100 MHz-style free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Drive a request at the current negedge; it is accepted on the next posedge
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin);
    start = 1'b1;
    a     = ta;
    b     = tb_v;
    bin   = tbin;
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    bin   = 1'($urandom);
  endtask

  // Wait for done (bounded), checking latency, busy length and results.
  // poke >= 0 pulses a spurious start with a=0xFF at that RUN cycle.
  task automatic wait_check(input string tag, input logic [W-1:0] ed, input logic eb,
                            input logic [2:0] eflags, input int poke);
    int cycles;
    int busy_cnt;
    cycles   = 0;
    busy_cnt = 0;
    while (!done && cycles < 20) begin
      if (busy) busy_cnt++;
      if (cycles == poke) begin
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'h00;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(cycles), 32'd8);
    check({tag, "_busy_len"}, 32'(busy_cnt), 32'd8);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    check({tag, "_diff"}, 32'(diff), 32'(ed));
    check({tag, "_bout"}, 32'(bout), 32'(eb));
`ifdef SERIAL_SUB_FLAGS_EN
    check({tag, "_flags"}, 32'({zero, neg, ovf}), 32'(eflags));
`else
    if (eflags === 3'bxxx) $display("unreachable");
`endif
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    a       = '0;
    b       = '0;
    bin     = 1'b0;

    // Reset state
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_FLAGS_EN
    check("rst_flags", 32'({zero, neg, ovf}), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 5 - 3 with a spurious start at RUN cycle 3 that must be ignored
    start_op(8'h05, 8'h03, 1'b0);
    wait_check("sub_5_3", 8'h02, 1'b0, 3'b000, 3);
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
    check("idle_hold_diff", 32'(diff), 32'h02);
    check("idle_busy", 32'(busy), 32'd0);

    // 3 - 5 wraps: borrow out, negative
    @(negedge clk);
    start_op(8'h03, 8'h05, 1'b0);
    wait_check("sub_3_5", 8'hFE, 1'b1, 3'b010, -1);

    // 0 - 0 - 1
    @(negedge clk);
    start_op(8'h00, 8'h00, 1'b1);
    wait_check("sub_bin", 8'hFF, 1'b1, 3'b010, -1);

    // Equal operands give zero
    @(negedge clk);
    start_op(8'h5A, 8'h5A, 1'b0);
    wait_check("sub_eq", 8'h00, 1'b0, 3'b100, -1);

    // Signed overflow cases, second one accepted back-to-back from DONE
    @(negedge clk);
    start_op(8'h80, 8'h01, 1'b0);
    wait_check("sub_ovf", 8'h7F, 1'b0, 3'b001, -1);
    start_op(8'h7F, 8'hFF, 1'b0);
    wait_check("sub_b2b", 8'h80, 1'b1, 3'b011, -1);

    // Reset at RUN cycle 4 aborts the op and clears outputs
    @(negedge clk);
    start_op(8'h10, 8'h01, 1'b0);
    repeat (3) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_diff", 32'(diff), 32'd0);
    check("arst_bout", 32'(bout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int done_seen;
      done_seen = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (done || busy) done_seen++;
      end
      check("arst_no_done", 32'(done_seen), 32'd0);
    end

    // Normal operation after abort
    start_op(8'h10, 8'h01, 1'b0);
    wait_check("post_rst", 8'h0F, 1'b0, 3'b000, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
